// File: rtl/stage_sequencer.sv
// ============================================================================
// Module   : stage_sequencer
// Brief    : Multi-cycle five-stage instruction sequencer with memory
//            handshakes, timeout fault, halt, run/step control and retire count.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module stage_sequencer #(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int COUNT_WIDTH    = 32
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   run,
    input  logic                   step,
    input  logic                   imem_ready,
    input  logic                   dmem_ready,
    input  logic                   needs_mem,
    input  logic                   halt_req,
    output logic [4:0]             stage,
    output logic                   fetch_req,
    output logic                   dmem_req,
    output logic                   retired,
    output logic                   halted,
    output logic                   fault,
    output logic [COUNT_WIDTH-1:0] retire_count
);

    localparam int c_WAIT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [c_WAIT_W-1:0] c_WAIT_LAST = c_WAIT_W'(TIMEOUT_CYCLES - 1);

    localparam logic [4:0] c_STAGE_NONE   = 5'b00000;
    localparam logic [4:0] c_STAGE_FETCH  = 5'b00001;
    localparam logic [4:0] c_STAGE_DECODE = 5'b00010;
    localparam logic [4:0] c_STAGE_EXEC   = 5'b00100;
    localparam logic [4:0] c_STAGE_DATA   = 5'b01000;
    localparam logic [4:0] c_STAGE_WB     = 5'b10000;

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_EXEC   = 4'd3,
        S_DATA   = 4'd4,
        S_WB     = 4'd5,
        S_HALT   = 4'd6,
        S_FAULT  = 4'd7
    } state_t;

    state_t                  r_state;
    state_t                  w_next_state;
    logic [c_WAIT_W-1:0]     r_wait_cnt;
    logic                    r_needs_mem;
    logic                    r_halt_latched;
    logic [COUNT_WIDTH-1:0]  r_retire_count;

    logic w_waiting;
    logic w_mem_ready;
    logic w_timeout;

    assign w_waiting   = (r_state == S_FETCH) || (r_state == S_DATA);
    assign w_mem_ready = (r_state == S_FETCH) ? imem_ready : dmem_ready;
    // Ready on the last allowed cycle takes precedence over the timeout.
    assign w_timeout   = w_waiting && !w_mem_ready && (r_wait_cnt == c_WAIT_LAST);

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (run || step) begin
                    w_next_state = S_FETCH;
                end
            end
            S_FETCH: begin
                if (imem_ready) begin
                    w_next_state = S_DECODE;
                end else if (w_timeout) begin
                    w_next_state = S_FAULT;
                end
            end
            S_DECODE: begin
                w_next_state = halt_req ? S_HALT : S_EXEC;
            end
            S_EXEC: begin
                w_next_state = r_needs_mem ? S_DATA : S_WB;
            end
            S_DATA: begin
                if (dmem_ready) begin
                    w_next_state = S_WB;
                end else if (w_timeout) begin
                    w_next_state = S_FAULT;
                end
            end
            S_WB: begin
                w_next_state = run ? S_FETCH : S_IDLE;
            end
            S_HALT:  w_next_state = S_HALT;
            S_FAULT: w_next_state = S_FAULT;
            default: w_next_state = S_IDLE;
        endcase
    end

    // Counter is zero whenever not stalled, so every entry to a wait state starts fresh.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_wait_cnt <= '0;
        end else if (w_waiting && !w_mem_ready && !w_timeout) begin
            r_wait_cnt <= r_wait_cnt + c_WAIT_W'(1);
        end else begin
            r_wait_cnt <= '0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_needs_mem    <= 1'b0;
            r_halt_latched <= 1'b0;
        end else if (r_state == S_DECODE) begin
            r_needs_mem    <= needs_mem;
            r_halt_latched <= halt_req;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_retire_count <= '0;
        end else if (r_state == S_WB) begin
            r_retire_count <= r_retire_count + COUNT_WIDTH'(1);
        end
    end

    always_comb begin
        stage = c_STAGE_NONE;
        case (r_state)
            S_FETCH:  stage = c_STAGE_FETCH;
            S_DECODE: stage = c_STAGE_DECODE;
            S_EXEC:   stage = c_STAGE_EXEC;
            S_DATA:   stage = c_STAGE_DATA;
            S_WB:     stage = c_STAGE_WB;
            default:  stage = c_STAGE_NONE;
        endcase
    end

    assign fetch_req    = (r_state == S_FETCH);
    assign dmem_req     = (r_state == S_DATA);
    assign retired      = (r_state == S_WB);
    assign halted       = (r_state == S_HALT) && r_halt_latched;
    assign fault        = (r_state == S_FAULT);
    assign retire_count = r_retire_count;

endmodule

`default_nettype wire

// File: tb/tb_stage_sequencer.sv
// ============================================================================
// Module   : tb_stage_sequencer
// Brief    : Directed self-checking bench for stage_sequencer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_stage_sequencer;

    localparam logic [4:0] ST_I = 5'b00000;
    localparam logic [4:0] ST_F = 5'b00001;
    localparam logic [4:0] ST_D = 5'b00010;
    localparam logic [4:0] ST_E = 5'b00100;
    localparam logic [4:0] ST_M = 5'b01000;
    localparam logic [4:0] ST_W = 5'b10000;

    logic       clock = 1'b0;
    logic       reset;
    logic       run;
    logic       step;
    logic       imem_ready;
    logic       dmem_ready;
    logic       needs_mem;
    logic       halt_req;
    logic [4:0] stage;
    logic       fetch_req;
    logic       dmem_req;
    logic       retired;
    logic       halted;
    logic       fault;
    logic [3:0] retire_count;

    typedef struct packed {
        logic [4:0] stage;
        logic       fetch_req;
        logic       dmem_req;
        logic       retired;
        logic       halted;
        logic       fault;
        logic [3:0] count;
    } exp_t;

    exp_t       sb[$];
    logic [3:0] cnt;
    int         checks   = 0;
    int         failures = 0;
    int         cycle    = 0;

    always #5 clock = ~clock;

    stage_sequencer #(
        .TIMEOUT_CYCLES(16),
        .COUNT_WIDTH   (4)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .run         (run),
        .step        (step),
        .imem_ready  (imem_ready),
        .dmem_ready  (dmem_ready),
        .needs_mem   (needs_mem),
        .halt_req    (halt_req),
        .stage       (stage),
        .fetch_req   (fetch_req),
        .dmem_req    (dmem_req),
        .retired     (retired),
        .halted      (halted),
        .fault       (fault),
        .retire_count(retire_count)
    );

    task automatic cmp(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, cycle, obs, exp);
        end
    endtask

    // Push the expectation for the state entered on the next edge, then compare.
    task automatic expect_cycle(input logic [4:0] st, input logic h, input logic f);
        exp_t e;
        exp_t got;
        e.stage     = st;
        e.fetch_req = (st == ST_F);
        e.dmem_req  = (st == ST_M);
        e.retired   = (st == ST_W);
        e.halted    = h;
        e.fault     = f;
        e.count     = cnt;
        sb.push_back(e);
        @(posedge clock);
        #1;
        cycle++;
        got = sb.pop_front();
        cmp("stage",        {3'b0, stage},        {3'b0, got.stage});
        cmp("fetch_req",    {7'b0, fetch_req},    {7'b0, got.fetch_req});
        cmp("dmem_req",     {7'b0, dmem_req},     {7'b0, got.dmem_req});
        cmp("retired",      {7'b0, retired},      {7'b0, got.retired});
        cmp("halted",       {7'b0, halted},       {7'b0, got.halted});
        cmp("fault",        {7'b0, fault},        {7'b0, got.fault});
        cmp("retire_count", {4'b0, retire_count}, {4'b0, got.count});
        if (st == ST_W) cnt = cnt + 4'd1;
    endtask

    task automatic plain_instr();
        expect_cycle(ST_F, 1'b0, 1'b0);
        expect_cycle(ST_D, 1'b0, 1'b0);
        expect_cycle(ST_E, 1'b0, 1'b0);
        expect_cycle(ST_W, 1'b0, 1'b0);
    endtask

    initial begin
        reset = 1'b1; run = 1'b0; step = 1'b0; imem_ready = 1'b0;
        dmem_ready = 1'b0; needs_mem = 1'b0; halt_req = 1'b0;
        cnt = 4'd0;
        expect_cycle(ST_I, 1'b0, 1'b0);
        expect_cycle(ST_I, 1'b0, 1'b0);

        // Free run, no memory: 4-cycle instructions
        reset = 1'b0; run = 1'b1; imem_ready = 1'b1;
        repeat (3) plain_instr();

        // Memory instruction with 3 stalled DATA cycles
        expect_cycle(ST_F, 1'b0, 1'b0);
        expect_cycle(ST_D, 1'b0, 1'b0);
        needs_mem = 1'b1;
        expect_cycle(ST_E, 1'b0, 1'b0);
        needs_mem = 1'b0;
        expect_cycle(ST_M, 1'b0, 1'b0);
        expect_cycle(ST_M, 1'b0, 1'b0);
        expect_cycle(ST_M, 1'b0, 1'b0);
        expect_cycle(ST_M, 1'b0, 1'b0);
        dmem_ready = 1'b1;
        expect_cycle(ST_W, 1'b0, 1'b0);
        dmem_ready = 1'b0; run = 1'b0;
        expect_cycle(ST_I, 1'b0, 1'b0);

        // Single step; second step during EXEC is ignored
        step = 1'b1;
        expect_cycle(ST_F, 1'b0, 1'b0);
        step = 1'b0;
        expect_cycle(ST_D, 1'b0, 1'b0);
        expect_cycle(ST_E, 1'b0, 1'b0);
        step = 1'b1;
        expect_cycle(ST_W, 1'b0, 1'b0);
        step = 1'b0;
        expect_cycle(ST_I, 1'b0, 1'b0);
        expect_cycle(ST_I, 1'b0, 1'b0);

        // Fetch timeout: 16 FETCH cycles then sticky fault
        imem_ready = 1'b0; step = 1'b1;
        expect_cycle(ST_F, 1'b0, 1'b0);
        step = 1'b0;
        repeat (15) expect_cycle(ST_F, 1'b0, 1'b0);
        expect_cycle(ST_I, 1'b0, 1'b1);
        run = 1'b1; step = 1'b1; imem_ready = 1'b1;
        expect_cycle(ST_I, 1'b0, 1'b1);
        expect_cycle(ST_I, 1'b0, 1'b1);
        run = 1'b0; step = 1'b0; imem_ready = 1'b0; reset = 1'b1;
        cnt = 4'd0;
        expect_cycle(ST_I, 1'b0, 1'b0);
        reset = 1'b0;

        // Ready on the 16th FETCH cycle wins
        step = 1'b1;
        expect_cycle(ST_F, 1'b0, 1'b0);
        step = 1'b0;
        repeat (15) expect_cycle(ST_F, 1'b0, 1'b0);
        imem_ready = 1'b1;
        expect_cycle(ST_D, 1'b0, 1'b0);
        expect_cycle(ST_E, 1'b0, 1'b0);
        expect_cycle(ST_W, 1'b0, 1'b0);
        expect_cycle(ST_I, 1'b0, 1'b0);

        // Halt on system instruction
        run = 1'b1;
        expect_cycle(ST_F, 1'b0, 1'b0);
        expect_cycle(ST_D, 1'b0, 1'b0);
        halt_req = 1'b1;
        expect_cycle(ST_I, 1'b1, 1'b0);
        halt_req = 1'b0; step = 1'b1;
        expect_cycle(ST_I, 1'b1, 1'b0);
        expect_cycle(ST_I, 1'b1, 1'b0);
        step = 1'b0; reset = 1'b1;
        cnt = 4'd0;
        expect_cycle(ST_I, 1'b0, 1'b0);
        reset = 1'b0;

        // 17 retirements: count wraps through 0 to 1
        repeat (17) plain_instr();

        // Reset during a DATA stall
        expect_cycle(ST_F, 1'b0, 1'b0);
        expect_cycle(ST_D, 1'b0, 1'b0);
        needs_mem = 1'b1;
        expect_cycle(ST_E, 1'b0, 1'b0);
        expect_cycle(ST_M, 1'b0, 1'b0);
        expect_cycle(ST_M, 1'b0, 1'b0);
        reset = 1'b1;
        cnt = 4'd0;
        expect_cycle(ST_I, 1'b0, 1'b0);
        reset = 1'b0;

        // Data timeout from a fresh wait counter
        expect_cycle(ST_F, 1'b0, 1'b0);
        expect_cycle(ST_D, 1'b0, 1'b0);
        expect_cycle(ST_E, 1'b0, 1'b0);
        repeat (16) expect_cycle(ST_M, 1'b0, 1'b0);
        expect_cycle(ST_I, 1'b0, 1'b1);
        expect_cycle(ST_I, 1'b0, 1'b1);
        run = 1'b0; needs_mem = 1'b0; reset = 1'b1;
        expect_cycle(ST_I, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
